serial_bridge: RTL and testbench
================================

// Module: serial_bridge
// PURPOSE
//   Processor-side end of the byte serial port driven by data_memory: buffers received bytes
//   for CPU reads (serial_in/valid) and queues CPU-written bytes (serial_out/wren) for a UART
//   8N1 transmitter. Sits between the datapath serial pins and the board UART RX/TX.
//   Owns RX FIFO, TX FIFO and the TX bit serializer.
// PARAMETERS
//   CLKS_PER_BIT   434  clock cycles per UART bit (50 MHz / 115200), >= 2
//   RX_AW          4    RX FIFO address width; depth = 2**RX_AW
//   TX_AW          4    TX FIFO address width; depth = 2**TX_AW
// PORTS
//   clock               in   1  single system clock, all logic on rising edge
//   reset               in   1  synchronous, active-high
//   rx_byte_in          in   8  byte from external UART receiver
//   rx_strobe_in        in   1  1-cycle pulse: rx_byte_in valid, push to RX FIFO
//   serial_data_out     out  8  RX FIFO head byte (to datapath serial_in)
//   serial_valid_out    out  1  RX FIFO non-empty (to datapath serial_valid_in)
//   serial_rden_in      in   1  CPU consumed head byte (from datapath serial_rden_out)
//   serial_data_in      in   8  byte written by CPU (from datapath serial_out)
//   serial_wren_in      in   1  push serial_data_in to TX FIFO (from serial_wren_out)
//   serial_ready_out    out  1  TX FIFO not full (to datapath serial_ready_in)
//   tx_out              out  1  UART TX line, idle high
//   tx_busy_out         out  1  serializer mid-frame or TX FIFO non-empty
//   rx_overflow_out     out  1  sticky: RX byte dropped because FIFO full
// BEHAVIOUR
//   Reset (sync, active-high, overrides all): FIFOs emptied, pointers/counts 0; outputs
//     serial_valid_out=0, serial_data_out=8'h00, serial_ready_out=1, tx_out=1,
//     tx_busy_out=0, rx_overflow_out=0; serializer -> IDLE. Reset mid-frame aborts frame;
//     tx_out returns high on the cycle after the reset edge; partial frame never resumed.
//   RX FIFO: first-word fall-through; serial_data_out = mem[rd_ptr] combinationally,
//     8'h00 when empty. Push on rx_strobe_in is visible (valid=1) the cycle after.
//     Pop on serial_rden_in && valid; rden while empty ignored (no pointer change).
//     Full + strobe + rden same cycle: pop and push both done, count unchanged.
//     Full + strobe, no rden: byte dropped, rx_overflow_out set, stays 1 until reset.
//   TX FIFO: serial_ready_out = !full (combinational from count). Push on
//     serial_wren_in && !full; wren while full ignored even if serializer pops that
//     cycle. Simultaneous push and pop on non-full FIFO: both done.
//   Pointers wrap modulo depth; count is (AW+1) bits, 0..2**AW.
//   Serializer FSM, bit counter 0..CLKS_PER_BIT-1, data bit index 0..7:
//     IDLE : tx_out=1; if TX FIFO non-empty: pop head into shift reg -> START.
//     START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
//     DATA : tx_out=shift[0], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 -> STOP.
//     STOP : tx_out=1 for CLKS_PER_BIT cycles -> IDLE.
//   tx_out is registered; start bit begins the cycle after the pop. Frame = 10 bits =
//     10*CLKS_PER_BIT cycles; back-to-back bytes need 1 IDLE cycle between frames.
//   tx_busy_out = (state != IDLE) || TX FIFO non-empty.
// TESTING (bench uses CLKS_PER_BIT=4, RX_AW=TX_AW=2)
//   Reset: hold reset 3 cycles -> tx_out=1, serial_ready_out=1, serial_valid_out=0,
//     overflow=0.
//   RX order: strobe 8'h48, 8'h69 -> valid=1, data_out=8'h48; rden 1 cycle -> 8'h69;
//     rden -> valid=0.
//   RX overflow: 5 strobes 8'h01..8'h05, no rden -> overflow=1, reads 01..04, 05 lost;
//     full+strobe+rden same cycle -> no overflow, count stays 4.
//   TX frame: write 8'hA5 -> tx_out low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles,
//     then high 4 cycles; tx_busy_out falls after stop bit.
//   TX backpressure: write 6 bytes back-to-back -> serial_ready_out=0 while FIFO holds 4;
//     dropped writes never appear on tx_out; transmitted sequence in write order.
//   Reset mid-frame: reset during DATA bit 3 of 8'hFF -> tx_out=1 next cycle, FIFOs empty,
//     no further frames.

Source files
------------

// File: rtl/serial_bridge_if.sv
// ---------------------------------------------------------------
// serial_bridge_if : CPU serial port and UART byte/line signals
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface serial_bridge_if;
  logic [7:0] rx_byte_in;
  logic       rx_strobe_in;
  logic [7:0] serial_data_out;
  logic       serial_valid_out;
  logic       serial_rden_in;
  logic [7:0] serial_data_in;
  logic       serial_wren_in;
  logic       serial_ready_out;
  logic       tx_out;
  logic       tx_busy_out;
  logic       rx_overflow_out;

  modport master (
    output rx_byte_in, rx_strobe_in, serial_rden_in, serial_data_in, serial_wren_in,
    input  serial_data_out, serial_valid_out, serial_ready_out, tx_out, tx_busy_out,
           rx_overflow_out
  );

  modport slave (
    input  rx_byte_in, rx_strobe_in, serial_rden_in, serial_data_in, serial_wren_in,
    output serial_data_out, serial_valid_out, serial_ready_out, tx_out, tx_busy_out,
           rx_overflow_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_bridge.sv
// ---------------------------------------------------------------
// serial_bridge : RX/TX byte FIFOs plus UART 8N1 transmit serializer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module serial_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_AW        = 4,
  parameter int TX_AW        = 4
) (
  input  logic            clock,
  input  logic            reset,
  serial_bridge_if.slave  bus
);
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_overflow;
  logic             rx_empty, rx_full, rx_pop, rx_push, rx_drop;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_pop   = bus.serial_rden_in && !rx_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign rx_push  = bus.rx_strobe_in && (!rx_full || rx_pop);
  assign rx_drop  = bus.rx_strobe_in && rx_full && !rx_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
      if (rx_drop) rx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_byte_in;
  end

  assign bus.serial_data_out  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign bus.serial_valid_out = !rx_empty;
  assign bus.rx_overflow_out  = rx_overflow;

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_push  = bus.serial_wren_in && !tx_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.serial_data_in;
  end

  // ---------------- 8N1 serializer ----------------
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t        state, state_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          tx_reg, tx_next;
  logic          bit_done;

  assign bit_done = (bit_cnt == BIT_LAST);

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_done ? '0 : bit_cnt + CW'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    tx_next      = tx_reg;
    tx_pop       = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_next = '0;
        tx_next      = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          shift_next = tx_mem[tx_rd_ptr];
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_done) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx_reg  <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx_reg  <= tx_next;
    end
  end

  assign bus.tx_out           = tx_reg;
  assign bus.tx_busy_out      = (state != IDLE) || !tx_empty;
  assign bus.serial_ready_out = !tx_full;

endmodule

`default_nettype wire

// File: tb/tb_serial_bridge.sv
// ---------------------------------------------------------------
// tb_serial_bridge : directed + random checks against a queue model and a line decoder
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_serial_bridge;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_bridge_if bus ();

  serial_bridge #(.CLKS_PER_BIT(CPB), .RX_AW(2), .TX_AW(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] sent_q[$];
  logic [7:0] dec_q[$];
  logic       ovf_m = 1'b0;
  int         ser_timer = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line-level UART receiver: samples mid-bit on the falling clock edge
  int         dec_cnt = 0;
  logic       dec_active = 1'b0;
  logic [7:0] dec_byte = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      dec_active = 1'b0;
      dec_cnt    = 0;
    end else if (!dec_active) begin
      if (bus.tx_out === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == CPB / 2) begin
        if (dec_cnt / CPB >= 1 && dec_cnt / CPB <= 8)
          dec_byte[dec_cnt / CPB - 1] = bus.tx_out;
        else if (dec_cnt / CPB == 9) begin
          chk("stop_bit", {31'd0, bus.tx_out}, 32'd1);
          dec_q.push_back(dec_byte);
          dec_active = 1'b0;
        end
      end
    end
  end

  task automatic model_clear();
    rxq.delete(); txq.delete(); sent_q.delete(); dec_q.delete();
    ovf_m = 1'b0;
    ser_timer = 0;
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, bus.serial_valid_out}, {31'd0, rxq.size() > 0});
    chk("data_out", {24'd0, bus.serial_data_out}, {24'd0, (rxq.size() > 0) ? rxq[0] : 8'h00});
    chk("overflow", {31'd0, bus.rx_overflow_out}, {31'd0, ovf_m});
    chk("ready", {31'd0, bus.serial_ready_out}, {31'd0, txq.size() < DEPTH});
    chk("busy", {31'd0, bus.tx_busy_out}, {31'd0, (ser_timer > 0) || (txq.size() > 0)});
    if (ser_timer == 0) chk("tx_idle_high", {31'd0, bus.tx_out}, 32'd1);
  endtask

  // One clock cycle with given inputs; model advanced from the same inputs.
  task automatic step(input logic s, input logic [7:0] b, input logic rd,
                      input logic wr, input logic [7:0] wd);
    logic rx_pop_m, tx_pop_m, tx_push_m;
    bus.rx_strobe_in   = s;
    bus.rx_byte_in     = b;
    bus.serial_rden_in = rd;
    bus.serial_wren_in = wr;
    bus.serial_data_in = wd;
    rx_pop_m  = rd && (rxq.size() > 0);
    tx_pop_m  = (ser_timer == 0) && (txq.size() > 0);
    tx_push_m = wr && (txq.size() < DEPTH);
    @(posedge clk);
    #1;
    if (rx_pop_m) void'(rxq.pop_front());
    if (s) begin
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else ovf_m = 1'b1;
    end
    if (tx_pop_m) begin
      sent_q.push_back(txq.pop_front());
      ser_timer = FRAME;
    end else if (ser_timer > 0) ser_timer--;
    if (tx_push_m) txq.push_back(wd);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Let the transmitter empty, then compare decoded line bytes with model order
  task automatic drain_and_compare(input string tag);
    int guard = 0;
    while ((txq.size() > 0 || ser_timer > 0) && guard < 2000) begin
      idle(1);
      guard++;
    end
    chk({tag, "_drain_timeout"}, {31'd0, guard >= 2000}, 32'd0);
    idle(3);
    chk({tag, "_count"}, dec_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < dec_q.size(); i++)
      chk({tag, "_byte"}, {24'd0, dec_q[i]}, {24'd0, sent_q[i]});
    sent_q.delete();
    dec_q.delete();
  endtask

  initial begin
    logic [7:0] a5;
    logic [9:0] frame;
    a5 = 8'hA5;
    bus.rx_strobe_in = 1'b0; bus.rx_byte_in = 8'h00; bus.serial_rden_in = 1'b0;
    bus.serial_wren_in = 1'b0; bus.serial_data_in = 8'h00;

    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    check_outputs();
    chk("rst_tx", {31'd0, bus.tx_out}, 32'd1);
    rst = 1'b0;

    // RX ordering
    step(1'b1, 8'h48, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h69, 1'b0, 1'b0, 8'h00);
    chk("rx_head_48", {24'd0, bus.serial_data_out}, 32'h48);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("rx_head_69", {24'd0, bus.serial_data_out}, 32'h69);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("rx_empty", {31'd0, bus.serial_valid_out}, 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // RX full: simultaneous strobe+rden keeps no-overflow; then a dropped byte
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h0A, 1'b1, 1'b0, 8'h00);
    chk("full_pushpop_no_ovf", {31'd0, bus.rx_overflow_out}, 32'd0);
    step(1'b1, 8'h05, 1'b0, 1'b0, 8'h00);
    chk("ovf_set", {31'd0, bus.rx_overflow_out}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Single frame, cycle-exact waveform of 8'hA5
    frame = {1'b1, a5, 1'b0};
    step(1'b0, 8'h00, 1'b0, 1'b1, a5);
    for (int k = 0; k < FRAME; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("tx_frame_a5", {31'd0, bus.tx_out}, {31'd0, frame[k / CPB]});
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("busy_fall", {31'd0, bus.tx_busy_out}, 32'd0);
    drain_and_compare("tx_a5");

    // Back-to-back writes beyond FIFO capacity
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'hC0 + 8'(i));
    chk("bp_ready_low", {31'd0, bus.serial_ready_out}, 32'd0);
    drain_and_compare("tx_bp");

    // Randomized traffic on both directions
    for (int i = 0; i < 600; i++)
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 3) == 0,
           ($urandom % 16) == 0, 8'($urandom));
    drain_and_compare("rand");

    // Reset during data bit 3 of 8'hFF
    step(1'b1, 8'h33, 1'b0, 1'b1, 8'hFF);
    idle(1 + CPB + 3 * CPB);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tx", {31'd0, bus.tx_out}, 32'd1);
    chk("midrst_busy", {31'd0, bus.tx_busy_out}, 32'd0);
    chk("midrst_valid", {31'd0, bus.serial_valid_out}, 32'd0);
    chk("midrst_ready", {31'd0, bus.serial_ready_out}, 32'd1);
    rst = 1'b0;
    model_clear();
    idle(3 * FRAME);
    chk("midrst_no_frames", dec_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
